// File: rtl/udc_pkg.sv
// Shared defaults and the prescaler width helper for the up/down counter slice.
package udc_pkg;

  localparam int UDC_N_DEF        = 8;
  localparam int UDC_MODULO_DEF   = 256;
  localparam int UDC_PRESCALE_DEF = 1;

  // A PRESCALE of 1 still needs a 1-bit register so the port widths stay legal.
  function automatic int udc_ps_width(input int prescale);
    return (prescale > 1) ? $clog2(prescale) : 1;
  endfunction

endpackage

// File: rtl/udc_prescaler.sv
// Prescale counter: tick is combinational, high on the enabled cycle that ends a prescale period.
// No backpressure; enable=0 freezes the count, zero discards any partial count.
module udc_prescaler
  import udc_pkg::*;
#(
  parameter int PRESCALE = UDC_PRESCALE_DEF
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic zero,
  output logic tick
);

  localparam int             W    = udc_ps_width(PRESCALE);
  localparam logic [W-1:0]   LAST = W'(PRESCALE - 1);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (zero) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/up_down_counter_mod.sv
// Modulo up/down counter with prescaler, sync clear/load; Q and tc registered, 1 clock after the tick.
// No backpressure. Build option UDC_SATURATE_EN adds input sat to hold at the boundary instead of wrapping.
module up_down_counter_mod
  import udc_pkg::*;
#(
  parameter int N        = UDC_N_DEF,
  parameter int MODULO   = UDC_MODULO_DEF,
  parameter int PRESCALE = UDC_PRESCALE_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         enable,
  input  logic         up,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_val,
`ifdef UDC_SATURATE_EN
  input  logic         sat,
`endif
  output logic [N-1:0] Q,
  output logic         tc
);

  localparam logic [N-1:0] Q_MAX = N'(MODULO - 1);

  logic         tick;
  logic         sat_eff;
  logic [N-1:0] load_clamped;
  logic [N-1:0] q_nxt;
  logic         tc_nxt;

`ifdef UDC_SATURATE_EN
  assign sat_eff = sat;
`else
  assign sat_eff = 1'b0;
`endif

  udc_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .zero    (clear | load),
    .tick    (tick)
  );

  // Extra bit so MODULO == 2^N compares correctly (no clamp needed then).
  assign load_clamped = ({1'b0, load_val} >= (N+1)'(MODULO)) ? Q_MAX : load_val;

  always_comb begin
    q_nxt  = Q;
    tc_nxt = 1'b0;
    if (clear) begin
      q_nxt = '0;
    end else if (load) begin
      q_nxt = load_clamped;
    end else if (tick) begin
      if (up) begin
        if (Q == Q_MAX) begin
          tc_nxt = 1'b1;
          q_nxt  = sat_eff ? Q_MAX : '0;
        end else begin
          q_nxt = Q + 1'b1;
        end
      end else begin
        if (Q == '0) begin
          tc_nxt = 1'b1;
          q_nxt  = sat_eff ? '0 : Q_MAX;
        end else begin
          q_nxt = Q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      Q  <= '0;
      tc <= 1'b0;
    end else begin
      Q  <= q_nxt;
      tc <= tc_nxt;
    end
  end

endmodule
